// File: rtl/drac_pkg.sv
// Shared core types for the CSR access path: command encoding and CSR address width.
package drac_pkg;

  localparam int CSR_ADDR_SIZE = 12;

  typedef enum logic [2:0] {
    CSR_CMD_NOPE  = 3'd0,
    CSR_CMD_WRITE = 3'd1,
    CSR_CMD_SET   = 3'd2,
    CSR_CMD_CLEAR = 3'd3,
    CSR_CMD_SYS   = 3'd4,
    CSR_CMD_READ  = 3'd5
  } csr_cmd_t;

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Bundle of writeback-side request signals and CSR-file-side signals for csr_access_ctrl.
interface csr_access_ctrl_if;
  import drac_pkg::*;

  logic                     req_valid_i;
  csr_cmd_t                 req_cmd_i;
  logic [CSR_ADDR_SIZE-1:0] req_addr_i;
  logic [63:0]              req_data_i;
  logic                     kill_i;
  logic                     req_ready_o;
  logic                     stall_o;

  logic                     csr_req_valid_o;
  csr_cmd_t                 csr_cmd_o;
  logic [CSR_ADDR_SIZE-1:0] csr_addr_o;
  logic [63:0]              csr_data_o;
  logic                     csr_resp_valid_i;
  logic [63:0]              csr_rdata_i;
  logic                     csr_xcpt_i;

  logic                     rdata_valid_o;
  logic [63:0]              rdata_o;
  logic                     xcpt_o;
  logic                     timeout_o;
  logic                     flush_o;

  modport slave (
    input  req_valid_i, req_cmd_i, req_addr_i, req_data_i, kill_i,
    input  csr_resp_valid_i, csr_rdata_i, csr_xcpt_i,
    output req_ready_o, stall_o,
    output csr_req_valid_o, csr_cmd_o, csr_addr_o, csr_data_o,
    output rdata_valid_o, rdata_o, xcpt_o, timeout_o, flush_o
  );

  modport master (
    output req_valid_i, req_cmd_i, req_addr_i, req_data_i, kill_i,
    output csr_resp_valid_i, csr_rdata_i, csr_xcpt_i,
    input  req_ready_o, stall_o,
    input  csr_req_valid_o, csr_cmd_o, csr_addr_o, csr_data_o,
    input  rdata_valid_o, rdata_o, xcpt_o, timeout_o, flush_o
  );

endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences one CSR access from writeback to the CSR file: issue, wait with timeout,
// then a single-cycle completion carrying read data, exception and flush indication.
module csr_access_ctrl
  import drac_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  csr_access_ctrl_if.slave bus
);

  localparam int unsigned      DATA_W   = 64;
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
    $error("csr_access_ctrl: TIMEOUT_CYCLES must lie in 2..1024");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                   state_q,   state_d;
  logic [CNT_W-1:0]         cnt_q,     cnt_d;
  csr_cmd_t                 cmd_q,     cmd_d;
  logic [CSR_ADDR_SIZE-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0]        data_q,    data_d;
  logic [DATA_W-1:0]        rdata_q,   rdata_d;
  logic                     xcpt_q,    xcpt_d;
  logic                     timeout_q, timeout_d;
  logic                     accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= CSR_CMD_NOPE;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      xcpt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      xcpt_q    <= xcpt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    xcpt_d    = xcpt_q;
    timeout_d = timeout_q;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept = bus.req_valid_i && (bus.req_cmd_i != CSR_CMD_NOPE) && !bus.kill_i;
        if (accept) begin
          cmd_d   = bus.req_cmd_i;
          addr_d  = bus.req_addr_i;
          data_d  = bus.req_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        // A kill here drops the access before anything reaches the CSR file.
        if (bus.kill_i) begin
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The response takes priority over an expiring timeout in the same cycle.
        if (bus.csr_resp_valid_i) begin
          rdata_d   = bus.csr_rdata_i;
          xcpt_d    = bus.csr_xcpt_i;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          xcpt_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_ready_o     = (state_q == IDLE);
    bus.stall_o         = accept || (state_q == REQ) || (state_q == WAIT);
    bus.csr_req_valid_o = (state_q == REQ) && !bus.kill_i;
    bus.csr_cmd_o       = cmd_q;
    bus.csr_addr_o      = addr_q;
    bus.csr_data_o      = data_q;
    bus.rdata_valid_o   = (state_q == DONE);
    bus.rdata_o         = rdata_q;
    bus.xcpt_o          = xcpt_q;
    bus.timeout_o       = (state_q == DONE) && timeout_q;
    // A system command retires by flushing the pipeline, unless it trapped.
    bus.flush_o         = (state_q == DONE) && (cmd_q == CSR_CMD_SYS) && !xcpt_q;
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed and randomized bench for csr_access_ctrl with a transaction-level completion model.
module tb_csr_access_ctrl;
  import drac_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_rd;
  logic        last_x;
  csr_cmd_t    cmds [5];
  csr_cmd_t    rcmd;
  int          rk;
  logic        rkill;

  csr_access_ctrl_if ifc ();

  csr_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Outcome of an issued access whose response arrives in WAIT cycle k (k=0: never).
  function automatic void predict(input int k, input csr_cmd_t cmd, input logic [63:0] rd,
                                  input logic x, output int nwait, output logic [63:0] erd,
                                  output logic ex, output logic eto, output logic efl);
    if (k >= 1 && k <= TO) begin
      nwait = k; erd = rd; ex = x; eto = 1'b0;
    end else begin
      nwait = TO; erd = 64'd0; ex = 1'b1; eto = 1'b1;
    end
    efl = (cmd == CSR_CMD_SYS) && !ex;
  endfunction

  task automatic drive_noise(input logic hold, input csr_cmd_t cmd);
    ifc.req_valid_i = hold ? 1'b1 : 1'($urandom);
    ifc.req_cmd_i   = hold ? cmd : cmds[$urandom_range(0, 4)];
    ifc.req_addr_i  = CSR_ADDR_SIZE'($urandom);
    ifc.req_data_i  = rnd64();
  endtask

  task automatic check_latched(input string tag, input csr_cmd_t cmd,
                               input logic [CSR_ADDR_SIZE-1:0] addr, input logic [63:0] data);
    check64({tag, "_cmd"}, 64'(ifc.csr_cmd_o), 64'(cmd));
    check64({tag, "_addr"}, 64'(ifc.csr_addr_o), 64'(addr));
    check64({tag, "_data"}, ifc.csr_data_o, data);
  endtask

  // Starts in IDLE just after a clock edge; ends just after the edge leaving DONE (or REQ on kill).
  task automatic run_txn(input csr_cmd_t cmd, input logic [CSR_ADDR_SIZE-1:0] addr,
                         input logic [63:0] data, input int k, input logic [63:0] rd,
                         input logic x, input logic kill_req, input logic kill_wait,
                         input logic hold);
    int          nwait;
    logic [63:0] erd;
    logic        ex, eto, efl;
    predict(k, cmd, rd, x, nwait, erd, ex, eto, efl);

    ifc.req_valid_i      = 1'b1;
    ifc.req_cmd_i        = cmd;
    ifc.req_addr_i       = addr;
    ifc.req_data_i       = data;
    ifc.kill_i           = 1'b0;
    ifc.csr_resp_valid_i = 1'($urandom);
    ifc.csr_rdata_i      = rnd64();
    ifc.csr_xcpt_i       = 1'($urandom);
    #1;
    check1("idle_ready", ifc.req_ready_o, 1'b1);
    check1("idle_stall", ifc.stall_o, 1'b1);
    check1("idle_rvalid", ifc.rdata_valid_o, 1'b0);
    check64("idle_rdata_hold", ifc.rdata_o, last_rd);
    check1("idle_xcpt_hold", ifc.xcpt_o, last_x);
    step();

    drive_noise(hold, cmd);
    ifc.kill_i           = kill_req;
    ifc.csr_resp_valid_i = 1'($urandom);
    ifc.csr_rdata_i      = rnd64();
    ifc.csr_xcpt_i       = 1'($urandom);
    #1;
    check1("req_strobe", ifc.csr_req_valid_o, !kill_req);
    check1("req_ready", ifc.req_ready_o, 1'b0);
    check1("req_stall", ifc.stall_o, 1'b1);
    check1("req_rvalid", ifc.rdata_valid_o, 1'b0);
    check_latched("req", cmd, addr, data);
    step();

    if (kill_req) begin
      ifc.req_valid_i      = 1'b0;
      ifc.kill_i           = 1'b0;
      ifc.csr_resp_valid_i = 1'b0;
      return;
    end

    for (int w = 1; w <= nwait; w++) begin
      drive_noise(hold, cmd);
      ifc.kill_i           = kill_wait ? 1'b1 : 1'($urandom);
      ifc.csr_resp_valid_i = (w == k);
      ifc.csr_rdata_i      = (w == k) ? rd : rnd64();
      ifc.csr_xcpt_i       = (w == k) ? x : 1'($urandom);
      #1;
      check1("wait_strobe", ifc.csr_req_valid_o, 1'b0);
      check1("wait_stall", ifc.stall_o, 1'b1);
      check1("wait_ready", ifc.req_ready_o, 1'b0);
      check1("wait_rvalid", ifc.rdata_valid_o, 1'b0);
      check1("wait_timeout", ifc.timeout_o, 1'b0);
      check_latched("wait", cmd, addr, data);
      step();
    end

    drive_noise(hold, cmd);
    ifc.kill_i           = 1'($urandom);
    ifc.csr_resp_valid_i = 1'($urandom);
    ifc.csr_rdata_i      = rnd64();
    ifc.csr_xcpt_i       = 1'($urandom);
    #1;
    check1("done_rvalid", ifc.rdata_valid_o, 1'b1);
    check64("done_rdata", ifc.rdata_o, erd);
    check1("done_xcpt", ifc.xcpt_o, ex);
    check1("done_timeout", ifc.timeout_o, eto);
    check1("done_flush", ifc.flush_o, efl);
    check1("done_stall", ifc.stall_o, 1'b0);
    check1("done_ready", ifc.req_ready_o, 1'b0);
    check1("done_strobe", ifc.csr_req_valid_o, 1'b0);
    check_latched("done", cmd, addr, data);
    last_rd = erd;
    last_x  = ex;
    if (!hold) ifc.req_valid_i = 1'b0;
    ifc.req_cmd_i        = cmd;
    ifc.kill_i           = 1'b0;
    ifc.csr_resp_valid_i = 1'b0;
    step();
  endtask

  initial begin
    cmds = '{CSR_CMD_WRITE, CSR_CMD_SET, CSR_CMD_CLEAR, CSR_CMD_SYS, CSR_CMD_READ};
    rst                  = 1'b1;
    ifc.req_valid_i      = 1'b0;
    ifc.req_cmd_i        = CSR_CMD_NOPE;
    ifc.req_addr_i       = '0;
    ifc.req_data_i       = '0;
    ifc.kill_i           = 1'b0;
    ifc.csr_resp_valid_i = 1'b0;
    ifc.csr_rdata_i      = '0;
    ifc.csr_xcpt_i       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check1("rst_ready", ifc.req_ready_o, 1'b1);
    check1("rst_stall", ifc.stall_o, 1'b0);
    check1("rst_strobe", ifc.csr_req_valid_o, 1'b0);
    check1("rst_rvalid", ifc.rdata_valid_o, 1'b0);
    check1("rst_timeout", ifc.timeout_o, 1'b0);
    check1("rst_flush", ifc.flush_o, 1'b0);
    check64("rst_rdata", ifc.rdata_o, 64'd0);
    check1("rst_xcpt", ifc.xcpt_o, 1'b0);
    check_latched("rst", CSR_CMD_NOPE, '0, 64'd0);
    last_rd = 64'd0;
    last_x  = 1'b0;
    step();

    run_txn(CSR_CMD_READ, 12'h300, rnd64(), 1, 64'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(CSR_CMD_SYS, 12'h105, rnd64(), 2, rnd64(), 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(CSR_CMD_SYS, 12'h105, rnd64(), 1, rnd64(), 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn(CSR_CMD_READ, 12'h341, rnd64(), 0, rnd64(), 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(CSR_CMD_READ, 12'h342, rnd64(), TO, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(CSR_CMD_WRITE, 12'h140, rnd64(), 1, rnd64(), 1'b0, 1'b1, 1'b0, 1'b0);
    run_txn(CSR_CMD_SET, 12'h300, rnd64(), 2, rnd64(), 1'b0, 1'b0, 1'b1, 1'b0);

    ifc.req_valid_i = 1'b1;
    ifc.req_cmd_i   = CSR_CMD_READ;
    ifc.kill_i      = 1'b1;
    #1;
    check1("kill_idle_stall", ifc.stall_o, 1'b0);
    step();
    ifc.req_valid_i = 1'b0;
    ifc.kill_i      = 1'b0;
    #1;
    check1("kill_idle_ready", ifc.req_ready_o, 1'b1);
    check1("kill_idle_strobe", ifc.csr_req_valid_o, 1'b0);
    step();

    ifc.req_valid_i = 1'b1;
    ifc.req_cmd_i   = CSR_CMD_CLEAR;
    ifc.req_addr_i  = 12'h300;
    step();
    ifc.req_valid_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst                  = 1'b0;
    ifc.csr_resp_valid_i = 1'b1;
    ifc.csr_rdata_i      = rnd64();
    #1;
    check1("rstw_rvalid", ifc.rdata_valid_o, 1'b0);
    check1("rstw_ready", ifc.req_ready_o, 1'b1);
    check1("rstw_stall", ifc.stall_o, 1'b0);
    check64("rstw_rdata", ifc.rdata_o, 64'd0);
    step();
    #1;
    check1("rstw_rvalid2", ifc.rdata_valid_o, 1'b0);
    check1("rstw_ready2", ifc.req_ready_o, 1'b1);
    ifc.csr_resp_valid_i = 1'b0;
    last_rd = 64'd0;
    last_x  = 1'b0;
    step();

    run_txn(CSR_CMD_WRITE, 12'h180, rnd64(), 1, rnd64(), 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn(CSR_CMD_WRITE, 12'h181, rnd64(), 2, rnd64(), 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ifc.req_valid_i = 1'b1;
      ifc.req_cmd_i   = CSR_CMD_NOPE;
      ifc.req_addr_i  = CSR_ADDR_SIZE'($urandom);
      ifc.req_data_i  = rnd64();
      #1;
      check1("nope_ready", ifc.req_ready_o, 1'b1);
      check1("nope_stall", ifc.stall_o, 1'b0);
      check1("nope_strobe", ifc.csr_req_valid_o, 1'b0);
      check1("nope_rvalid", ifc.rdata_valid_o, 1'b0);
      step();
    end
    ifc.req_valid_i = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rcmd  = cmds[$urandom_range(0, 4)];
      rk    = int'($urandom_range(0, TO + 1));
      rkill = ($urandom_range(0, 7) == 0);
      run_txn(rcmd, CSR_ADDR_SIZE'($urandom), rnd64(), rk, rnd64(), 1'($urandom),
              rkill, 1'b0, 1'b0);
    end

    #1;
    check1("end_ready", ifc.req_ready_o, 1'b1);
    check64("end_rdata_hold", ifc.rdata_o, last_rd);
    check1("end_xcpt_hold", ifc.xcpt_o, last_x);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
